// File: rtl/avalon_timer_master.sv
// -----------------------------------------------------------------------------
// avalon_timer_master
//
// Avalon-MM master that runs the 16-bit-register interval timer slave without
// a CPU. It programs the period, starts the timer in continuous mode with its
// interrupt enabled, clears the status register on every timeout and turns
// each serviced timeout into a tick pulse and a running tick count. On request
// it strobes the slave's snapshot register and reads the captured counter back.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   cfg_period        timer period, sampled when a start is accepted
//   cfg_start         pulse: (re)program and start the timer
//   cfg_stop          pulse: stop the timer
//   snap_req          pulse: capture and read back the live counter
//   m_address         slave register: 0 status, 1 control, 2/3 period l/h,
//                     4/5 snapshot l/h
//   m_chipselect      one-cycle access strobe
//   m_write_n         0 write, 1 read
//   m_writedata       write data
//   m_readdata        slave read data, valid the cycle after the address
//   timer_irq         slave timeout interrupt (level)
//   busy              sequencer is not in IDLE or RUN
//   running           timer started and not stopped
//   tick              one-cycle pulse per serviced timeout
//   tick_count        serviced timeouts since the last start (wraps)
//   snap_value        last snapshot {snap_h, snap_l}
//   snap_valid        one-cycle pulse when snap_value updates
//
// States
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | timer stopped, waiting for cfg_start
//   W_STOP     | write CTRL_STOP to control
//   W_PL       | write period[15:0]
//   W_PH       | write period[31:16]
//   W_CLR      | clear any stale timeout in status
//   W_RUN      | write CTRL_RUN to control
//   RUN        | bus idle, arbitrate stop > start > irq > snapshot
//   W_ACK      | clear status to acknowledge the timeout
//   ACK_WAIT   | idle cycle so the slave's registered irq can fall
//   W_SNAP     | write the snapshot strobe register
//   RA_L/RC_L  | read snapshot low: address cycle / capture cycle
//   RA_H/RC_H  | read snapshot high: address cycle / capture cycle
// -----------------------------------------------------------------------------
module avalon_timer_master #(
    parameter int unsigned TICK_W    = 16,
    parameter logic [3:0]  CTRL_RUN  = 4'h7,
    parameter logic [3:0]  CTRL_STOP = 4'h8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              timer_irq,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PER_L  = 3'd2;
    localparam logic [2:0] ADDR_PER_H  = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_STOP,
        S_W_PL,
        S_W_PH,
        S_W_CLR,
        S_W_RUN,
        S_RUN,
        S_W_ACK,
        S_ACK_WAIT,
        S_W_SNAP,
        S_RA_L,
        S_RC_L,
        S_RA_H,
        S_RC_H
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        period_q, period_d;
    logic [31:0]        pend_period_q, pend_period_d;
    logic               pend_start_q, pend_start_d;
    logic               pend_stop_q, pend_stop_d;
    logic               pend_snap_q, pend_snap_d;
    logic               seq_start_q, seq_start_d;

    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [2:0]         addr_q, addr_d;
    logic [15:0]        wd_q, wd_d;

    logic               running_q;
    logic               tick_q;
    logic [TICK_W-1:0]  tick_count_q;
    logic [15:0]        snap_lo_q;
    logic [31:0]        snap_value_q;
    logic               snap_valid_q;

    logic               stop_r, start_r, snap_r;
    logic [31:0]        start_period;

    // Sequencer: next state, request latching and period capture.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        pend_period_d = pend_period_q;
        pend_start_d  = pend_start_q;
        pend_stop_d   = pend_stop_q;
        pend_snap_d   = pend_snap_q;
        seq_start_d   = seq_start_q;

        // A request is live either from its pin this cycle or from a flag
        // latched while the sequencer was busy.
        stop_r       = cfg_stop | pend_stop_q;
        start_r      = cfg_start | pend_start_q;
        snap_r       = snap_req | pend_snap_q;
        start_period = cfg_start ? cfg_period : pend_period_q;

        unique case (state_q)
            S_IDLE: begin
                pend_stop_d = 1'b0;
                pend_snap_d = 1'b0;
                if (start_r) begin
                    state_d      = S_W_STOP;
                    period_d     = start_period;
                    pend_start_d = 1'b0;
                    seq_start_d  = 1'b1;
                end
            end

            S_RUN: begin
                if (stop_r) begin
                    state_d     = S_W_STOP;
                    seq_start_d = 1'b0;
                    pend_stop_d = 1'b0;
                    pend_snap_d = 1'b0;
                    // A start arriving on the pin while an older stop is
                    // pending came after that stop, so it survives and
                    // restarts the timer from IDLE.
                    if (cfg_start && !cfg_stop) begin
                        pend_start_d  = 1'b1;
                        pend_period_d = cfg_period;
                    end else begin
                        pend_start_d = 1'b0;
                    end
                end else if (start_r) begin
                    state_d      = S_W_STOP;
                    period_d     = start_period;
                    seq_start_d  = 1'b1;
                    pend_start_d = 1'b0;
                    pend_snap_d  = snap_r;
                end else if (timer_irq) begin
                    state_d     = S_W_ACK;
                    pend_snap_d = snap_r;
                end else if (snap_r) begin
                    state_d     = S_W_SNAP;
                    pend_snap_d = 1'b0;
                end
            end

            default: begin
                // Busy: hold one flag per request. A stop cancels anything
                // that was queued before it.
                if (cfg_stop) begin
                    pend_stop_d  = 1'b1;
                    pend_start_d = 1'b0;
                    pend_snap_d  = 1'b0;
                end else begin
                    if (cfg_start) begin
                        pend_start_d  = 1'b1;
                        pend_period_d = cfg_period;
                    end
                    if (snap_req) begin
                        pend_snap_d = 1'b1;
                    end
                end

                unique case (state_q)
                    S_W_STOP:   state_d = seq_start_q ? S_W_PL : S_IDLE;
                    S_W_PL:     state_d = S_W_PH;
                    S_W_PH:     state_d = S_W_CLR;
                    S_W_CLR:    state_d = S_W_RUN;
                    S_W_RUN: begin
                        state_d     = S_RUN;
                        seq_start_d = 1'b0;
                    end
                    S_W_ACK:    state_d = S_ACK_WAIT;
                    S_ACK_WAIT: state_d = S_RUN;
                    S_W_SNAP:   state_d = S_RA_L;
                    S_RA_L:     state_d = S_RC_L;
                    S_RC_L:     state_d = S_RA_H;
                    S_RA_H:     state_d = S_RC_H;
                    S_RC_H:     state_d = S_RUN;
                    default:    state_d = S_IDLE;
                endcase
            end
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so each
    // access is presented during the cycle its state is current.
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = ADDR_STATUS;
        wd_d   = 16'h0000;
        unique case (state_d)
            S_W_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CTRL;
                wd_d = {12'h000, CTRL_STOP};
            end
            S_W_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PER_L;
                wd_d = period_q[15:0];
            end
            S_W_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PER_H;
                wd_d = period_q[31:16];
            end
            S_W_CLR, S_W_ACK: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;
            end
            S_W_RUN: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CTRL;
                wd_d = {12'h000, CTRL_RUN};
            end
            S_W_SNAP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SNAP_L;
            end
            S_RA_L: begin
                cs_d = 1'b1; addr_d = ADDR_SNAP_L;
            end
            S_RA_H: begin
                cs_d = 1'b1; addr_d = ADDR_SNAP_H;
            end
            default: begin
                cs_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            period_q      <= 32'h0;
            pend_period_q <= 32'h0;
            pend_start_q  <= 1'b0;
            pend_stop_q   <= 1'b0;
            pend_snap_q   <= 1'b0;
            seq_start_q   <= 1'b0;
            cs_q          <= 1'b0;
            wn_q          <= 1'b1;
            addr_q        <= 3'd0;
            wd_q          <= 16'h0000;
            running_q     <= 1'b0;
            tick_q        <= 1'b0;
            tick_count_q  <= '0;
            snap_lo_q     <= 16'h0000;
            snap_value_q  <= 32'h0;
            snap_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            pend_period_q <= pend_period_d;
            pend_start_q  <= pend_start_d;
            pend_stop_q   <= pend_stop_d;
            pend_snap_q   <= pend_snap_d;
            seq_start_q   <= seq_start_d;
            cs_q          <= cs_d;
            wn_q          <= wn_d;
            addr_q        <= addr_d;
            wd_q          <= wd_d;

            // A reprogram passes through W_STOP with seq_start set and keeps
            // running high; only a real stop drops it.
            if (state_q == S_W_RUN) begin
                running_q <= 1'b1;
            end else if (state_q == S_W_STOP && !seq_start_q) begin
                running_q <= 1'b0;
            end

            tick_q <= (state_q == S_W_ACK);
            if (state_q == S_W_RUN) begin
                tick_count_q <= '0;
            end else if (state_q == S_W_ACK) begin
                tick_count_q <= tick_count_q + TICK_W'(1);
            end

            if (state_q == S_RC_L) begin
                snap_lo_q <= m_readdata;
            end
            if (state_q == S_RC_H) begin
                snap_value_q <= {m_readdata, snap_lo_q};
            end
            snap_valid_q <= (state_q == S_RC_H);
        end
    end

    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_address    = addr_q;
    assign m_writedata  = wd_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_RUN);
    assign running      = running_q;
    assign tick         = tick_q;
    assign tick_count   = tick_count_q;
    assign snap_value   = snap_value_q;
    assign snap_valid   = snap_valid_q;

endmodule

// File: tb/tb_avalon_timer_master.sv
module tb_avalon_timer_master;

    logic        clk;
    logic        reset_n;
    logic [31:0] cfg_period;
    logic        cfg_start;
    logic        cfg_stop;
    logic        snap_req;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
    logic        timer_irq;
    logic        busy;
    logic        running;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;

    int errors = 0;
    int checks = 0;

    avalon_timer_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_period   (cfg_period),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .snap_req     (snap_req),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .timer_irq    (timer_irq),
        .busy         (busy),
        .running      (running),
        .tick         (tick),
        .tick_count   (tick_count),
        .snap_value   (snap_value),
        .snap_valid   (snap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- interval timer slave model ----------------
    logic [31:0] s_period, s_cnt, s_snap;
    logic        s_run, s_cont, s_ito, s_to;
    logic [15:0] s_rd;
    logic        snap_force_en;
    logic [31:0] snap_force_val;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_period <= 32'h0; s_cnt <= 32'h0; s_snap <= 32'h0;
            s_run <= 1'b0; s_cont <= 1'b0; s_ito <= 1'b0; s_to <= 1'b0;
            s_rd <= 16'h0;
        end else begin
            if (s_run) begin
                if (s_cnt == 32'h0) begin
                    s_to  <= 1'b1;
                    s_cnt <= s_period;
                    if (!s_cont) s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 32'h1;
                end
            end
            if (m_chipselect && !m_write_n) begin
                case (m_address)
                    3'd0: s_to <= 1'b0;
                    3'd1: begin
                        if (m_writedata[3]) s_run <= 1'b0;
                        if (m_writedata[2]) begin
                            s_run <= 1'b1;
                            s_cnt <= s_period;
                        end
                        s_cont <= m_writedata[1];
                        s_ito  <= m_writedata[0];
                    end
                    3'd2: s_period[15:0]  <= m_writedata;
                    3'd3: s_period[31:16] <= m_writedata;
                    3'd4: s_snap <= snap_force_en ? snap_force_val : s_cnt;
                    default: ;
                endcase
            end
            if (m_chipselect && m_write_n) begin
                case (m_address)
                    3'd0:    s_rd <= {15'h0, s_to};
                    3'd4:    s_rd <= s_snap[15:0];
                    3'd5:    s_rd <= s_snap[31:16];
                    default: s_rd <= 16'h0;
                endcase
            end
        end
    end

    assign m_readdata = s_rd;
    assign timer_irq  = s_to & s_ito;

    // ---------------- bus / event monitor and tick reference ----------------
    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t wr_q[$];
    int  wr_cyc[$];
    int  cyc = 0;
    int  model_ticks = 0;   // timeouts expected to be serviced since last start
    int  irq_rises = 0;
    int  tick_pulses = 0;
    int  snapv_cnt = 0;
    int  irq_cyc = 0;
    int  max_lat = 0;
    bit  ack_pend = 0;
    bit  seen_run = 0;
    logic irq_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (m_chipselect && !m_write_n) begin
            wr_q.push_back({m_address, m_writedata});
            wr_cyc.push_back(cyc);
            if (m_address == 3'd1 && m_writedata == 16'h0007) begin
                model_ticks = 0;
                seen_run = 1;
            end
            if (ack_pend && m_address == 3'd0 && m_writedata == 16'h0) begin
                if (cyc - irq_cyc > max_lat) max_lat = cyc - irq_cyc;
                ack_pend = 0;
            end
        end
        if (timer_irq && !irq_prev) begin
            model_ticks++;
            irq_rises++;
            irq_cyc = cyc;
            ack_pend = 1;
        end
        irq_prev = timer_irq;
        if (tick) tick_pulses++;
        if (snap_valid) snapv_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_and_wait(input string tag, input logic [31:0] p);
        int n;
        @(negedge clk);
        wr_q.delete();
        wr_cyc.delete();
        seen_run = 0;
        cfg_period = p;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        n = 0;
        while (!(seen_run && busy === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, n < 200, 1);
    endtask

    task automatic check_start_writes(input string tag, input logic [31:0] p);
        wr_t exp[5];
        exp[0] = {3'd1, 16'h0008};
        exp[1] = {3'd2, p[15:0]};
        exp[2] = {3'd3, p[31:16]};
        exp[3] = {3'd0, 16'h0000};
        exp[4] = {3'd1, 16'h0007};
        check({tag, "_nwr"}, wr_q.size(), 5);
        for (int i = 0; i < 5 && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp[i]);
        if (wr_cyc.size() == 5)
            check({tag, "_b2b"}, wr_cyc[4] - wr_cyc[0], 4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] p;
        logic [31:0] sv;
        int k;
        int tp0;

        reset_n = 1'b0;
        cfg_period = 32'h0; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
        snap_force_en = 1'b1; snap_force_val = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_bus", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        check("rst_flags", {busy, running, tick, snap_valid}, 4'b0000);
        check("rst_tick_count", tick_count, 16'h0);
        check("rst_snap_value", snap_value, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Start from IDLE with the reference period.
        start_and_wait("start", 32'h0001_86A0);
        check_start_writes("start", 32'h0001_86A0);
        check("start_run_busy", {running, busy}, 2'b10);
        check("start_tick_count", tick_count, 16'h0);

        // Reprogram from RUN to period 9 and collect five ticks.
        start_and_wait("p9", 32'd9);
        check_start_writes("p9", 32'd9);
        irq_rises = 0; tick_pulses = 0; max_lat = 0; ack_pend = 0;
        k = 0;
        while (tick_pulses < 5 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("ticks_wait", k < 300, 1);
        check("ticks_count", tick_count, 16'd5);
        check("ticks_vs_irqs", tick_pulses, irq_rises);
        check("ticks_model", tick_count, 16'(model_ticks));
        check("ack_latency_le2", max_lat <= 2, 1);

        // Snapshots: the reference value first, then a random one.
        p = 32'h0010_0000 + $urandom_range(0, 32'h000F_FFFF);
        start_and_wait("big1", p);
        for (int i = 0; i < 2; i++) begin
            sv = (i == 0) ? 32'h0005_1234 : $urandom;
            snap_force_val = sv;
            snapv_cnt = 0;
            @(negedge clk);
            snap_req = 1'b1;
            @(negedge clk);
            snap_req = 1'b0;
            k = 1;
            while (snap_valid !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("snap%0d_latency", i), k, 6);
            check($sformatf("snap%0d_value", i), snap_value, sv);
            repeat (3) @(negedge clk);
            check($sformatf("snap%0d_pulses", i), snapv_cnt, 1);
        end

        // IRQ and snapshot in the same RUN cycle.
        p = 32'd20 + $urandom_range(0, 10);
        start_and_wait("coll", p);
        sv = $urandom;
        snap_force_val = sv;
        k = 0;
        while (timer_irq !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("coll_irq_wait", k < 60, 1);
        tp0 = tick_pulses;
        wr_q.delete();
        wr_cyc.delete();
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        k = 0;
        while (snap_valid !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("coll_snap_wait", k < 30, 1);
        check("coll_one_tick", tick_pulses - tp0, 1);
        check("coll_tick_count", tick_count, 16'(model_ticks));
        check("coll_snap_value", snap_value, sv);
        check("coll_nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("coll_ack_first", wr_q[0], {3'd0, 16'h0000});
            check("coll_snap_second", wr_q[1], {3'd4, 16'h0000});
        end

        // Stop arriving during a snapshot read while another snapshot waits.
        p = 32'h0010_0000 + $urandom_range(0, 32'h000F_FFFF);
        start_and_wait("big2", p);
        sv = $urandom;
        snap_force_val = sv;
        snapv_cnt = 0;
        wr_q.delete();
        wr_cyc.delete();
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        k = 0;
        while (!(running === 1'b0 && busy === 1'b0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("stop_wait", k < 40, 1);
        repeat (10) @(negedge clk);
        check("stop_snap_once", snapv_cnt, 1);
        check("stop_snap_value", snap_value, sv);
        check("stop_idle", {running, busy}, 2'b00);
        check("stop_nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("stop_wr0", wr_q[0], {3'd4, 16'h0000});
            check("stop_wr1", wr_q[1], {3'd1, 16'h0008});
        end

        // Reset in the middle of W_PH.
        p = $urandom;
        @(negedge clk);
        cfg_period = p;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (2) @(negedge clk);
        check("wph_bus", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b1, 1'b0, 3'd3, p[31:16]});
        #2 reset_n = 1'b0;
        #1;
        check("arst_chipselect", m_chipselect, 1'b0);
        check("arst_bus", {m_write_n, m_address, m_writedata}, {1'b1, 3'd0, 16'h0});
        check("arst_flags", {busy, running, tick, snap_valid}, 4'b0000);
        check("arst_tick_count", tick_count, 16'h0);
        check("arst_snap_value", snap_value, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wr_q.delete();
        wr_cyc.delete();
        repeat (5) @(negedge clk);
        check("post_rst_quiet", wr_q.size(), 0);
        check("post_rst_idle", {busy, running}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/avalon_timer_master.md
Name: avalon_timer_master

Overview:
- Avalon-MM master that drives the team's 16-bit-register interval timer slave from hardware, so no CPU is needed to run a periodic tick.
- Programs the period, starts the timer in continuous mode with interrupt enabled, and services each timeout IRQ by clearing the status register.
- Emits a one-cycle tick pulse and a running tick count on each serviced timeout.
- On request, snapshots the live counter and reads it back over the bus.

Parameters:
- TICK_W, 16, width of tick_count (wraps modulo 2^TICK_W).
- CTRL_RUN, 4'h7, control word written to start the timer (START|CONT|ITO).
- CTRL_STOP, 4'h8, control word written to stop the timer.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_period  in  32  timer period; sampled when cfg_start is accepted.
- cfg_start  in  1  pulse: (re)program and start the timer.
- cfg_stop  in  1  pulse: stop the timer.
- snap_req  in  1  pulse: capture and read back the timer counter.
- m_address  out  3  slave register address: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- m_chipselect  out  1  bus access strobe.
- m_write_n  out  1  0 = write, 1 = read.
- m_writedata  out  16  write data.
- m_readdata  in  16  slave read data; registered, valid the cycle after the address is presented.
- timer_irq  in  1  timer slave interrupt (level).
- busy  out  1  FSM is not in IDLE or RUN.
- running  out  1  timer has been started and not stopped.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_W  serviced timeouts since the last start.
- snap_value  out  32  last snapshot {snap_h, snap_l}.
- snap_valid  out  1  one-cycle pulse when snap_value is updated.

Behaviour:
- Reset values (async, reset_n low):
  - state = IDLE.
  - m_chipselect = 0, m_write_n = 1, m_address = 0, m_writedata = 0.
  - busy = 0, running = 0, tick = 0, tick_count = 0, snap_value = 0, snap_valid = 0.
- Bus rules:
  - Single-cycle accesses; no waitrequest.
  - m_chipselect is high for exactly one cycle per access.
  - All master outputs are registered.
- Reads take two states:
  - RA: address driven with chipselect = 1 and write_n = 1.
  - RC: chipselect = 0; m_readdata is captured at the end of RC.
- States and transitions:
  - IDLE:
    - cfg_start latches cfg_period, then goes to W_STOP.
    - cfg_stop and snap_req are ignored.
  - W_STOP: write addr 1 = CTRL_STOP.
    - Next state is W_PL if a start sequence is in progress, else IDLE with running = 0.
  - W_PL: write addr 2 = period[15:0]. Then W_PH.
  - W_PH: write addr 3 = period[31:16]. Then W_CLR.
  - W_CLR: write addr 0 = 0, clearing any stale timeout. Then W_RUN.
  - W_RUN: write addr 1 = CTRL_RUN.
    - Sets running = 1 and clears tick_count to 0. Then RUN.
  - RUN: bus idle. Evaluated each cycle with priority cfg_stop > cfg_start > timer_irq > snap_req:
    - cfg_stop: W_STOP, then IDLE.
    - cfg_start: latch the new period; full reprogram via W_STOP.
    - timer_irq: W_ACK.
    - snap_req: W_SNAP.
  - W_ACK: write addr 0 = 0. Then ACK_WAIT.
  - ACK_WAIT: one idle cycle, so the registered irq can fall.
    - tick pulses and tick_count increments on entry.
    - Then RUN.
  - W_SNAP: write addr 4 = 0 (snapshot strobe). Then RA(4), RC(4), RA(5), RC(5).
    - After RC(5), snap_value = {hi, lo} and snap_valid pulses for 1 cycle. Then RUN.
- Request latching:
  - cfg_stop, cfg_start and snap_req arriving while busy are latched as one pending flag each; duplicates are dropped.
  - Pending flags are serviced in RUN by the same priority.
  - cfg_stop clears a pending snap_req and a pending cfg_start that arrived before it.
- IRQ arrival:
  - timer_irq is level; an IRQ that asserts during a snapshot or ack sequence is serviced on the next RUN cycle.
  - At most one tick per IRQ assertion.
- tick_count wraps from 2^TICK_W-1 to 0.
- busy = 1 in every state except IDLE and RUN.
- Reset mid-sequence: all state is cleared immediately; no bus cycle completes. The timer slave is assumed to be reset by the same reset_n.

Test Plan:
- Start: cfg_period = 0x0001_86A0, cfg_start, with a timer slave model attached.
  - Required write sequence: (1, 0x8), (2, 0x86A0), (3, 0x0001), (0, 0), (1, 0x7), one per cycle.
  - Then running = 1 and busy = 0.
- Continuous ticks: period = 9 with a slave model.
  - 5 IRQs produce 5 tick pulses and tick_count = 5.
  - Each IRQ is followed by a write to addr 0 within 2 cycles; no double ticks.
- Snapshot: snap_req in RUN with the slave model returning snap_l = 0x1234 and snap_h = 0x0005.
  - snap_value = 0x0005_1234.
  - snap_valid pulses once, 6 cycles after acceptance.
- Collision: timer_irq and snap_req asserted in the same RUN cycle.
  - Ack sequence first, then snapshot; both complete.
  - tick_count increments by 1.
- Stop priority: cfg_stop during a snapshot read with snap_req pending.
  - Snapshot finishes, then write (1, 0x8), then IDLE with running = 0.
  - No further snapshot occurs.
- Reset: reset_n low during W_PH.
  - All outputs return to reset values asynchronously.
  - m_chipselect = 0 on the same edge.
